// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch stage and its consumers.
package cpu_pkg;

  localparam int AW = 10;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0]   inst;
    logic [AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO, data visible at head one cycle after push.
// Backpressure: push dropped when full without a pop; clr wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 3,
  parameter int W = 42,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the IM read port, buffers returns, hands words to decode.
// Latency 2 cycles issue-to-valid; issue stalls while buffered + in-flight words fill the buffer.
module fetch_unit #(
  parameter int AW = cpu_pkg::AW,
  parameter logic [AW-1:0] RESET_PC = AW'(cpu_pkg::RESET_PC),
  parameter int BUF_DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          IM_enable_fetch,
  output logic          IM_enable_write,
  output logic          IM_enable_mem,
  output logic [AW-1:0] IM_address,
  input  logic [31:0]   instruction,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc,
  output logic [1:0]    buf_count
);
  import cpu_pkg::*;

  localparam int EW = 32 + AW;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [AW-1:0] pc;
  logic [AW-1:0] tag_pc;
  logic          inflight;
  logic          fetch;
  logic          push;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  // Reserve a slot for the in-flight return so it can never overflow the buffer.
  assign fetch = !rst && !redirect_valid && ((int'(count) + int'(inflight)) < BUF_DEPTH);

  assign IM_enable_fetch = fetch;
  assign IM_enable_mem   = fetch;
  assign IM_enable_write = 1'b0;
  assign IM_address      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= fetch;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (fetch) begin
        pc     <= pc + AW'(1);
        tag_pc <= pc;
      end
    end
  end

  // A return landing in a redirect cycle is wrong-path and never enters the buffer.
  assign push = inflight && !redirect_valid;
  assign pop  = !empty && inst_ready;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_valid),
    .push     (push),
    .push_dat ({instruction, tag_pc}),
    .pop      (pop),
    .head_dat (head),
    .empty    (empty),
    .count    (count)
  );

  assign inst_valid = !empty;
  assign inst       = empty ? NOP : head[EW-1:AW];
  assign inst_pc    = empty ? '0 : head[AW-1:0];
  assign buf_count  = 2'(count);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a synchronous IM model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          IM_enable_fetch;
  logic          IM_enable_write;
  logic          IM_enable_mem;
  logic [AW-1:0] IM_address;
  logic [31:0]   instruction = 32'h0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic [1:0]    buf_count;

  logic [31:0]   mem [1024];
  fetch_entry_t  sb [$];
  fetch_entry_t  mon_e;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .IM_enable_fetch (IM_enable_fetch),
    .IM_enable_write (IM_enable_write),
    .IM_enable_mem   (IM_enable_mem),
    .IM_address      (IM_address),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .buf_count       (buf_count)
  );

  always @(posedge clk) begin
    if (IM_enable_mem === 1'b1) instruction <= mem[IM_address];
  end

  always @(negedge clk) begin
    total++;
    if (IM_enable_write !== 1'b0 || IM_enable_mem !== IM_enable_fetch) begin
      bad++;
      $display("FAIL im_strobes write=%b mem=%b fetch=%b required write=0 mem=fetch",
               IM_enable_write, IM_enable_mem, IM_enable_fetch);
    end
    if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word inst=%h inst_pc=%h required none", inst, inst_pc);
      end else begin
        mon_e = sb.pop_front();
        if (inst !== mon_e.inst || inst_pc !== mon_e.pc) begin
          bad++;
          $display("FAIL delivered_word got inst=%h pc=%h required inst=%h pc=%h",
                   inst, inst_pc, mon_e.inst, mon_e.pc);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    next();
    next();
    sb.delete();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] p);
    fetch_entry_t e;
    e.inst = mem[p];
    e.pc = p;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) next();
    inst_ready = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain words_left=%0d required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    next();
    next();
    total++; if (IM_enable_fetch !== 1'b0) begin bad++; $display("FAIL rst_fetch got=%b required 0", IM_enable_fetch); end
    total++; if (IM_enable_mem !== 1'b0) begin bad++; $display("FAIL rst_mem got=%b required 0", IM_enable_mem); end
    total++; if (IM_address !== 10'h000) begin bad++; $display("FAIL rst_addr got=%h required 000", IM_address); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required 0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h required 0", inst); end
    total++; if (inst_pc !== 10'h000) begin bad++; $display("FAIL rst_inst_pc got=%h required 0", inst_pc); end
    total++; if (buf_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d required 0", buf_count); end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1;
    apply_reset();
    for (int k = 0; k < 4; k++) push_exp(AW'(k));
    total++; if (IM_enable_fetch !== 1'b1 || IM_address !== 10'h000) begin
      bad++; $display("FAIL stream_first_issue fetch=%b addr=%h required 1/000", IM_enable_fetch, IM_address); end
    next();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid got=%b required 0", inst_valid); end
    next();
    total++; if (inst_valid !== 1'b1 || inst !== 32'h11 || inst_pc !== 10'h000) begin
      bad++; $display("FAIL stream_first_word valid=%b inst=%h pc=%h required 1/11/000", inst_valid, inst, inst_pc); end
    for (int k = 1; k < 4; k++) begin
      next();
      total++; if (inst_valid !== 1'b1 || inst_pc !== AW'(k)) begin
        bad++; $display("FAIL stream_consecutive valid=%b pc=%h required 1/%h", inst_valid, inst_pc, k); end
    end
    next();
    inst_ready = 1'b0;
    @(negedge clk);
    #1;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_left words=%0d required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] addrs [3];
    int n;
    n = 0;
    inst_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (IM_enable_fetch === 1'b1) begin
        if (n < 3) addrs[n] = IM_address;
        n++;
      end
      next();
    end
    total++; if (n != 3) begin bad++; $display("FAIL bp_issue_count got=%0d required 3", n); end
    for (int i = 0; i < 3; i++) begin
      total++; if (n > i && addrs[i] !== AW'(i)) begin
        bad++; $display("FAIL bp_issue_addr got=%h required %h", addrs[i], i); end
    end
    total++; if (IM_enable_fetch !== 1'b0 || buf_count !== 2'd3) begin
      bad++; $display("FAIL bp_full fetch=%b count=%0d required 0/3", IM_enable_fetch, buf_count); end
    for (int k = 0; k < 4; k++) push_exp(AW'(k));
    drain("bp");
  endtask

  task automatic test_redirect_full();
    inst_ready = 1'b0;
    apply_reset();
    repeat (6) next();
    total++; if (buf_count !== 2'd3) begin bad++; $display("FAIL rdf_prefull count=%0d required 3", buf_count); end
    redirect_valid = 1'b1;
    redirect_pc = 10'h100;
    #1;
    total++; if (IM_enable_fetch !== 1'b0) begin bad++; $display("FAIL rdf_suppress fetch=%b required 0", IM_enable_fetch); end
    next();
    redirect_valid = 1'b0;
    #1;
    total++; if (buf_count !== 2'd0 || IM_address !== 10'h100 || IM_enable_fetch !== 1'b1) begin
      bad++; $display("FAIL rdf_flush count=%0d addr=%h fetch=%b required 0/100/1", buf_count, IM_address, IM_enable_fetch); end
    next();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdf_early_valid got=%b required 0", inst_valid); end
    next();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 10'h100 || inst !== mem[10'h100]) begin
      bad++; $display("FAIL rdf_target valid=%b pc=%h inst=%h required 1/100/%h", inst_valid, inst_pc, inst, mem[10'h100]); end
    push_exp(10'h100);
    push_exp(10'h101);
    drain("rdf");
  endtask

  task automatic test_redirect_return();
    inst_ready = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) push_exp(AW'(k));
    repeat (4) next();
    redirect_valid = 1'b1;
    redirect_pc = 10'h200;
    next();
    redirect_valid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || buf_count !== 2'd0) begin
      bad++; $display("FAIL rdr_flush valid=%b count=%0d required 0/0", inst_valid, buf_count); end
    push_exp(10'h200);
    push_exp(10'h201);
    drain("rdr");
  endtask

  task automatic test_back_to_back();
    inst_ready = 1'b0;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 10'h050;
    #1;
    total++; if (IM_enable_fetch !== 1'b0) begin bad++; $display("FAIL b2b_first fetch=%b required 0", IM_enable_fetch); end
    next();
    redirect_pc = 10'h060;
    #1;
    total++; if (IM_enable_fetch !== 1'b0) begin bad++; $display("FAIL b2b_second fetch=%b required 0", IM_enable_fetch); end
    next();
    redirect_valid = 1'b0;
    #1;
    total++; if (IM_enable_fetch !== 1'b1 || IM_address !== 10'h060) begin
      bad++; $display("FAIL b2b_target fetch=%b addr=%h required 1/060", IM_enable_fetch, IM_address); end
    push_exp(10'h060);
    drain("b2b");
  endtask

  task automatic test_wrap();
    inst_ready = 1'b0;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 10'h3FE;
    next();
    redirect_valid = 1'b0;
    #1;
    total++; if (IM_address !== 10'h3FE) begin bad++; $display("FAIL wrap_addr got=%h required 3fe", IM_address); end
    push_exp(10'h3FE);
    push_exp(10'h3FF);
    push_exp(10'h000);
    push_exp(10'h001);
    drain("wrap");
  endtask

  task automatic test_mid_reset();
    inst_ready = 1'b0;
    apply_reset();
    repeat (3) next();
    total++; if (buf_count !== 2'd2) begin bad++; $display("FAIL mrst_pre count=%0d required 2", buf_count); end
    rst = 1'b1;
    #1;
    total++; if (IM_enable_fetch !== 1'b0) begin bad++; $display("FAIL mrst_suppress fetch=%b required 0", IM_enable_fetch); end
    next();
    total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 10'h000 || buf_count !== 2'd0
                 || IM_address !== 10'h000 || IM_enable_fetch !== 1'b0) begin
      bad++; $display("FAIL mrst_values valid=%b inst=%h pc=%h count=%0d addr=%h fetch=%b required all 0",
                      inst_valid, inst, inst_pc, buf_count, IM_address, IM_enable_fetch); end
    rst = 1'b0;
    #1;
    total++; if (IM_enable_fetch !== 1'b1 || IM_address !== 10'h000) begin
      bad++; $display("FAIL mrst_restart fetch=%b addr=%h required 1/000", IM_enable_fetch, IM_address); end
    for (int k = 0; k < 4; k++) push_exp(AW'(k));
    drain("mrst");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_return();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    repeat (3) next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
